// File: rtl/decode_pkg.sv
// Shared decode constants and the control-word decoder for the ID stage.
// Opcode/funct encodings cover the supported MIPS32 subset only.
package decode_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
        logic    illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_none();
        ctrl_t c;
        c            = '0;
        c.alu_op     = ALU_ADD;
        return c;
    endfunction

    // Unsupported opcodes/functs decode with every side-effecting control cleared.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = ctrl_none();
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                case (funct)
                    F_ADD:   c.alu_op = ALU_ADD;
                    F_SUB:   c.alu_op = ALU_SUB;
                    F_AND:   c.alu_op = ALU_AND;
                    F_OR:    c.alu_op = ALU_OR;
                    F_SLT:   c.alu_op = ALU_SLT;
                    default: begin
                        c.reg_write = 1'b0;
                        c.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                c.alu_op = ALU_SUB;
                c.branch = 1'b1;
            end
            OP_J:    c.jump    = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file: two async read ports with write-through bypass, one sync write port.
// Register $0 is never written and always reads zero.
module reg_file
    import decode_pkg::*;
#(
    parameter int unsigned DW = XLEN,
    parameter int unsigned NR = NREGS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    input  logic          wb_en,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data
);

    logic [DW-1:0] r_regs [NR];
    logic          w_wr;

    assign w_wr = wb_en && (wb_addr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NR; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs_data = r_regs[rs_addr];
        if (rs_addr == '0)
            rs_data = '0;
        else if (w_wr && (wb_addr == rs_addr))
            rs_data = wb_data;
    end

    always_comb begin
        rt_data = r_regs[rt_addr];
        if (rt_addr == '0)
            rt_data = '0;
        else if (w_wr && (wb_addr == rt_addr))
            rt_data = wb_data;
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register-file read, control decode and the ID/EX output register.
// Edge priority: reset > flush > stall > load.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned          XLEN     = decode_pkg::XLEN,
    parameter int unsigned          NREGS    = decode_pkg::NREGS,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_instruction,
    input  logic [XLEN-1:0] if_pc_next,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc_next,
    output logic [XLEN-1:0] id_rs_data,
    output logic [XLEN-1:0] id_rt_data,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rs,
    output logic [4:0]      id_rt,
    output logic [4:0]      id_dest,
    output logic [2:0]      id_alu_op,
    output logic            id_alu_src,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_reg_write,
    output logic            id_mem_to_reg,
    output logic            id_branch,
    output logic            id_jump,
    output logic [XLEN-1:0] id_jump_target,
    output logic            id_illegal
);

    logic [5:0]      w_op;
    logic [5:0]      w_funct;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [4:0]      w_dest;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_jt;
    logic [XLEN-1:0] w_rs_data;
    logic [XLEN-1:0] w_rt_data;
    ctrl_t           w_ctrl;

    assign w_op    = if_instruction[31:26];
    assign w_rs    = if_instruction[25:21];
    assign w_rt    = if_instruction[20:16];
    assign w_rd    = if_instruction[15:11];
    assign w_funct = if_instruction[5:0];
    assign w_dest  = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_imm   = {{(XLEN-16){if_instruction[15]}}, if_instruction[15:0]};
    assign w_jt    = {if_pc_next[XLEN-1:XLEN-4], if_instruction[25:0], 2'b00};

    // A not-valid slot loads as a bubble so downstream never sees stray controls.
    always_comb begin
        w_ctrl = ctrl_none();
        if (if_valid)
            w_ctrl = decode_ctrl(w_op, w_funct);
    end

    reg_file #(
        .DW (XLEN),
        .NR (NREGS)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .rs_addr (w_rs),
        .rt_addr (w_rt),
        .rs_data (w_rs_data),
        .rt_data (w_rt_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid       <= 1'b0;
            id_pc_next     <= RESET_PC;
            id_rs_data     <= '0;
            id_rt_data     <= '0;
            id_imm         <= '0;
            id_rs          <= '0;
            id_rt          <= '0;
            id_dest        <= '0;
            id_alu_op      <= '0;
            id_alu_src     <= 1'b0;
            id_mem_read    <= 1'b0;
            id_mem_write   <= 1'b0;
            id_reg_write   <= 1'b0;
            id_mem_to_reg  <= 1'b0;
            id_branch      <= 1'b0;
            id_jump        <= 1'b0;
            id_jump_target <= '0;
            id_illegal     <= 1'b0;
        end else if (flush) begin
            // Data fields are left untouched; only the controls make the bubble.
            id_valid      <= 1'b0;
            id_alu_op     <= '0;
            id_alu_src    <= 1'b0;
            id_mem_read   <= 1'b0;
            id_mem_write  <= 1'b0;
            id_reg_write  <= 1'b0;
            id_mem_to_reg <= 1'b0;
            id_branch     <= 1'b0;
            id_jump       <= 1'b0;
            id_illegal    <= 1'b0;
        end else if (!stall) begin
            id_valid       <= if_valid;
            id_pc_next     <= if_pc_next;
            id_rs_data     <= w_rs_data;
            id_rt_data     <= w_rt_data;
            id_imm         <= w_imm;
            id_rs          <= w_rs;
            id_rt          <= w_rt;
            id_dest        <= w_dest;
            id_alu_op      <= w_ctrl.alu_op;
            id_alu_src     <= w_ctrl.alu_src;
            id_mem_read    <= w_ctrl.mem_read;
            id_mem_write   <= w_ctrl.mem_write;
            id_reg_write   <= w_ctrl.reg_write;
            id_mem_to_reg  <= w_ctrl.mem_to_reg;
            id_branch      <= w_ctrl.branch;
            id_jump        <= w_ctrl.jump;
            id_jump_target <= w_jt;
            id_illegal     <= w_ctrl.illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; expected outputs are queued when stimulus is driven
// and popped one cycle later when the ID/EX register presents them.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_next;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [31:0] id_pc_next;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_dest;
    logic [2:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_reg_write;
    logic        id_mem_to_reg;
    logic        id_branch;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic        id_illegal;

    decode_stage #(
        .XLEN     (32),
        .NREGS    (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc_next     (if_pc_next),
        .stall          (stall),
        .flush          (flush),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .id_valid       (id_valid),
        .id_pc_next     (id_pc_next),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_dest        (id_dest),
        .id_alu_op      (id_alu_op),
        .id_alu_src     (id_alu_src),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .id_reg_write   (id_reg_write),
        .id_mem_to_reg  (id_mem_to_reg),
        .id_branch      (id_branch),
        .id_jump        (id_jump),
        .id_jump_target (id_jump_target),
        .id_illegal     (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [11:0] ctrl;
        logic [5:0]  mask;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic [31:0] jt;
    } exp_t;

    localparam logic [5:0] M_PC   = 6'h01;
    localparam logic [5:0] M_RS   = 6'h02;
    localparam logic [5:0] M_RT   = 6'h04;
    localparam logic [5:0] M_IMM  = 6'h08;
    localparam logic [5:0] M_JT   = 6'h10;
    localparam logic [5:0] M_DEST = 6'h20;
    localparam logic [5:0] M_ALL  = 6'h3F;

    exp_t q[$];
    exp_t last;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [11:0] obs_ctrl;
    assign obs_ctrl = {id_valid, id_alu_op, id_alu_src, id_mem_read, id_mem_write,
                       id_reg_write, id_mem_to_reg, id_branch, id_jump, id_illegal};

    // {valid, alu_op, alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, illegal}
    function automatic logic [11:0] ctl(input logic v, input logic [2:0] op, input logic src,
                                        input logic mr, input logic mw, input logic rw,
                                        input logic m2r, input logic br, input logic j,
                                        input logic ill);
        return {v, op, src, mr, mw, rw, m2r, br, j, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [11:0] c, input logic [5:0] m,
                        input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] dest, input logic [31:0] jt);
        exp_t e;
        e.tag = tag; e.ctrl = c; e.mask = m; e.pc = pc; e.rsd = rsd;
        e.rtd = rtd; e.imm = imm; e.dest = dest; e.jt = jt;
        q.push_back(e);
        last = e;
    endtask

    task automatic push_hold(input string tag);
        exp_t e;
        e = last;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = q.pop_front();
        chk({e.tag, ".ctrl"}, {20'd0, obs_ctrl}, {20'd0, e.ctrl});
        if (e.mask[0]) chk({e.tag, ".pc_next"}, id_pc_next, e.pc);
        if (e.mask[1]) chk({e.tag, ".rs_data"}, id_rs_data, e.rsd);
        if (e.mask[2]) chk({e.tag, ".rt_data"}, id_rt_data, e.rtd);
        if (e.mask[3]) chk({e.tag, ".imm"}, id_imm, e.imm);
        if (e.mask[4]) chk({e.tag, ".jump_target"}, id_jump_target, e.jt);
        if (e.mask[5]) chk({e.tag, ".dest"}, {27'd0, id_dest}, {27'd0, e.dest});
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid       = v;
        if_instruction = ins;
        if_pc_next     = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [11:0] c_add;
        logic [31:0] ins;
        logic [4:0]  ra;
        c_add = ctl(1, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0);

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        drive(0, 32'h0, 32'h0);
        #1;
        push("reset", 12'd0, M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        check_out();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        drive(0, 32'h0, 32'h0);
        push("bubble", 12'd0, 6'h00, '0, '0, '0, '0, '0, '0);
        step();

        wb_en = 1'b0;
        drive(1, 32'h00A01820, 32'h00000104);
        push("add_r5", c_add, M_PC | M_RS | M_RT | M_IMM | M_DEST,
             32'h104, 32'hDEADBEEF, 32'h0, 32'h00001820, 5'd3, '0);
        step();

        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h00001234;
        drive(1, 32'h00E50820, 32'h00000108);
        push("bypass", c_add, M_RS | M_RT | M_DEST, '0, 32'h1234, 32'hDEADBEEF, '0, 5'd1, '0);
        step();

        wb_addr = 5'd0; wb_data = 32'h00000005;
        drive(1, 32'h00071020, 32'h0000010C);
        push("r0_write", c_add, M_RS | M_RT | M_DEST, '0, 32'h0, 32'h1234, '0, 5'd2, '0);
        step();

        wb_en = 1'b0;
        drive(1, 32'h00002022, 32'h00000110);
        push("sub_r0", ctl(1, 3'd1, 0, 0, 0, 1, 0, 0, 0, 0), M_RS | M_RT | M_DEST,
             '0, 32'h0, 32'h0, '0, 5'd4, '0);
        step();

        drive(1, 32'h8FA2FFFC, 32'h00000114);
        push("lw", ctl(1, 3'd0, 1, 1, 0, 1, 1, 0, 0, 0), M_PC | M_RS | M_IMM | M_DEST,
             32'h114, 32'h0, '0, 32'hFFFFFFFC, 5'd2, '0);
        step();

        drive(1, 32'hAC070008, 32'h00000118);
        push("sw", ctl(1, 3'd0, 1, 0, 1, 0, 0, 0, 0, 0), M_RT | M_IMM,
             '0, '0, 32'h1234, 32'h8, '0, '0);
        step();

        drive(1, 32'h10A70003, 32'h0000011C);
        push("beq", ctl(1, 3'd1, 0, 0, 0, 0, 0, 1, 0, 0), M_RS | M_RT | M_IMM,
             '0, 32'hDEADBEEF, 32'h1234, 32'h3, '0, '0);
        step();

        drive(1, 32'h20A9FFFF, 32'h00000120);
        push("addi", ctl(1, 3'd0, 1, 0, 0, 1, 0, 0, 0, 0), M_RS | M_IMM | M_DEST,
             '0, 32'hDEADBEEF, '0, 32'hFFFFFFFF, 5'd9, '0);
        step();

        drive(1, 32'h00A74024, 32'h00000124);
        push("and", ctl(1, 3'd2, 0, 0, 0, 1, 0, 0, 0, 0), M_RS | M_RT | M_DEST,
             '0, 32'hDEADBEEF, 32'h1234, '0, 5'd8, '0);
        step();

        drive(1, 32'h00A74025, 32'h00000128);
        push("or", ctl(1, 3'd3, 0, 0, 0, 1, 0, 0, 0, 0), M_DEST, '0, '0, '0, '0, 5'd8, '0);
        step();

        drive(1, 32'h00A7402A, 32'h00000130);
        push("slt", ctl(1, 3'd4, 0, 0, 0, 1, 0, 0, 0, 0), M_PC | M_RS | M_RT | M_IMM | M_DEST,
             32'h130, 32'hDEADBEEF, 32'h1234, 32'h0000402A, 5'd8, '0);
        step();

        stall = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'hCAFE0008;
        drive(1, 32'h8FA2FFFC, 32'h00000200);
        for (int i = 0; i < 3; i++) begin
            push_hold($sformatf("stall%0d", i));
            step();
        end

        flush = 1'b1;
        push("stall_flush", 12'd0, 6'h00, '0, '0, '0, '0, '0, '0);
        step();

        stall = 1'b0; wb_en = 1'b0;
        push("flush", 12'd0, 6'h00, '0, '0, '0, '0, '0, '0);
        step();
        flush = 1'b0;

        drive(1, 32'h01005020, 32'h00000204);
        push("stall_wb_r8", c_add, M_RS | M_DEST, '0, 32'hCAFE0008, '0, '0, 5'd10, '0);
        step();

        drive(1, 32'h08000100, 32'h40000004);
        push("jump", ctl(1, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0), M_PC | M_JT,
             32'h40000004, '0, '0, '0, '0, 32'h40000400);
        step();

        drive(1, 32'hFC000000, 32'h00000300);
        push("illegal_op", ctl(1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1), 6'h00, '0, '0, '0, '0, '0, '0);
        step();

        drive(1, 32'h00000003, 32'h00000304);
        push("illegal_funct", ctl(1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1), 6'h00, '0, '0, '0, '0, '0, '0);
        step();

        drive(0, 32'hFC000000, 32'h00000308);
        push("illegal_invalid", 12'd0, 6'h00, '0, '0, '0, '0, '0, '0);
        step();

        drive(1, 32'h00A74024, 32'h0000030C);
        #2;
        reset = 1'b1;
        #1;
        push("async_reset", 12'd0, M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        check_out();
        @(posedge clk); #1;
        reset = 1'b0;

        for (int unsigned r = 1; r < 32; r++) begin
            ra  = 5'(r);
            ins = {6'd0, ra, ra, 5'd1, 5'd0, 6'h20};
            drive(1, ins, 32'h0);
            push($sformatf("cleared_r%0d", r), c_add, M_RS | M_RT, '0, 32'h0, 32'h0, '0, '0, '0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
